// File: rtl/io_timer_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_timer_intc_pkg
// Description : Shared register map, bit positions and interrupt FSM state
//               encoding for the interval timer / interrupt requester.
//               Register index is the word select Addr[3:2]:
//               0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS.
// Revision    : 1.0 - initial release
// ============================================================================
package io_timer_intc_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [1:0] c_TMR_CTRL   = 2'd0;
    localparam logic [1:0] c_TMR_LOAD   = 2'd1;
    localparam logic [1:0] c_TMR_COUNT  = 2'd2;
    localparam logic [1:0] c_TMR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int c_CTRL_EN   = 0;
    localparam int c_CTRL_AUTO = 1;
    localparam int c_CTRL_IE   = 2;

    // STATUS bit positions
    localparam int c_STAT_TC  = 0;
    localparam int c_STAT_OVR = 1;

    typedef enum logic [1:0] {
        INT_IDLE = 2'd0,
        INT_PEND = 2'd1,
        INT_ACKW = 2'd2
    } int_state_e;

endpackage : io_timer_intc_pkg
`default_nettype wire

// File: rtl/io_timer_intc_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tmr_prescaler
// Description : Divides the system clock into timer ticks. A counter runs
//               0..PRESCALE-1 while en_i is high and tick_o pulses for one
//               cycle on the wrap. Dropping en_i returns the counter to 0.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               en_i   - count enable
//               tick_o - one-cycle tick pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tmr_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    generate
        if (PRESCALE <= 1) begin : g_div1
            // Every enabled cycle is a tick; no state required.
            assign tick_o = en_i;
        end else begin : g_divn
            localparam int              W    = $clog2(PRESCALE);
            localparam logic [W-1:0]    LAST = W'(PRESCALE - 1);

            logic [W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (!en_i || (cnt_q == LAST)) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign tick_o = en_i && (cnt_q == LAST);
        end
    endgenerate

endmodule : tmr_prescaler
`default_nettype wire

// File: rtl/io_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : io_timer_intc
// Description : Memory-mapped down-counting interval timer with an interrupt
//               request/acknowledge handshake toward the CPU.
// Ports       : sys_clk  - system clock (rising edge)
//               sys_rst  - asynchronous active-low reset
//               io_cs    - I/O chip select
//               io_rd    - read strobe (wins over io_wr)
//               io_wr    - write strobe
//               Addr     - byte address, [11:4] decoded against BASE_ADDR,
//                          [3:2] selects CTRL/LOAD/COUNT/STATUS
//               D_Out    - CPU write data
//               int_ack  - interrupt acknowledge level
//               DY_io    - combinational read data (0 when not reading)
//               intr     - registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module io_timer_intc
    import io_timer_intc_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'hFF0,
    parameter int          PRESCALE   = 4,
    parameter logic [31:0] RESET_LOAD = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] Addr,
    input  logic [31:0] D_Out,
    input  logic        int_ack,
    output logic [31:0] DY_io,
    output logic        intr
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic       w_rd;
    logic       w_wr;
    logic [1:0] w_idx;
    logic       w_cnt_wr;
    logic       w_unused_addr;

    assign w_sel    = io_cs && (Addr[11:4] == BASE_ADDR[11:4]);
    assign w_rd     = w_sel && io_rd;
    assign w_wr     = w_sel && io_wr && !io_rd;
    assign w_idx    = Addr[3:2];
    assign w_cnt_wr = w_wr && (w_idx == c_TMR_COUNT);

    assign w_unused_addr = ^{Addr[31:12], Addr[1:0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  ctrl_q,   ctrl_d;
    logic [31:0] load_q,   load_d;
    logic [31:0] count_q,  count_d;
    logic [1:0]  status_q, status_d;
    logic        tc_q,     tc_d;
    int_state_e  state_q;
    logic        intr_q;
    logic        w_tick;

    tmr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (sys_clk),
        .rst_n  (sys_rst),
        .en_i   (ctrl_q[c_CTRL_EN]),
        .tick_o (w_tick)
    );

    // ------------------------------------------------------------------
    // Down-counter and register writes. A CPU write to COUNT overrides
    // whatever the tick would have done, including the terminal count.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (w_tick && !w_cnt_wr) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
                if (count_q == 32'd1) begin
                    tc_d = 1'b1;
                    // One-shot mode stops itself at terminal count.
                    if (!ctrl_q[c_CTRL_AUTO]) begin
                        ctrl_d[c_CTRL_EN] = 1'b0;
                    end
                end
            end else if (ctrl_q[c_CTRL_AUTO]) begin
                // The tick after reaching zero is spent on the reload.
                count_d = load_q;
            end
        end

        if (w_cnt_wr) begin
            count_d = D_Out;
        end
        if (w_wr && (w_idx == c_TMR_CTRL)) begin
            ctrl_d = D_Out[2:0];
        end
        if (w_wr && (w_idx == c_TMR_LOAD)) begin
            load_d = D_Out;
        end
    end

    // STATUS: write-1-to-clear, with a simultaneous hardware set taking
    // priority. The terminal-count event is seen one cycle after COUNT
    // reaches zero (tc_q), in step with the interrupt FSM.
    always_comb begin
        status_d = status_q;
        if (w_wr && (w_idx == c_TMR_STATUS)) begin
            status_d = status_q & ~D_Out[1:0];
        end
        if (tc_q) begin
            status_d[c_STAT_TC] = 1'b1;
            if (state_q == INT_PEND) begin
                status_d[c_STAT_OVR] = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ctrl_q   <= '0;
            load_q   <= RESET_LOAD;
            count_q  <= '0;
            status_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            count_q  <= count_d;
            status_q <= status_d;
            tc_q     <= tc_d;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt FSM. ACKW holds off a new request until the acknowledge
    // level is released, so a long ack services exactly one request.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= INT_IDLE;
            intr_q  <= 1'b0;
        end else begin
            case (state_q)
                INT_IDLE: begin
                    if (tc_q && ctrl_q[c_CTRL_IE]) begin
                        state_q <= INT_PEND;
                        intr_q  <= 1'b1;
                    end
                end
                INT_PEND: begin
                    if (!ctrl_q[c_CTRL_IE]) begin
                        state_q <= INT_IDLE;
                        intr_q  <= 1'b0;
                    end else if (int_ack) begin
                        state_q <= INT_ACKW;
                        intr_q  <= 1'b0;
                    end
                end
                INT_ACKW: begin
                    intr_q <= 1'b0;
                    if (!int_ack) begin
                        state_q <= INT_IDLE;
                    end
                end
                default: begin
                    state_q <= INT_IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr = intr_q;

    // ------------------------------------------------------------------
    // Zero-latency read mux
    // ------------------------------------------------------------------
    always_comb begin
        DY_io = 32'h0;
        if (w_rd) begin
            case (w_idx)
                c_TMR_CTRL:   DY_io = {29'd0, ctrl_q};
                c_TMR_LOAD:   DY_io = load_q;
                c_TMR_COUNT:  DY_io = count_q;
                c_TMR_STATUS: DY_io = {30'd0, status_q};
                default:      DY_io = 32'h0;
            endcase
        end
    end

endmodule : io_timer_intc
`default_nettype wire

// File: tb/tb_io_timer_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_timer_intc
// Description : Self-checking bench. Two timers (tick every cycle, and tick
//               every third cycle) share one CPU bus. A behavioural model of
//               each timer predicts DY_io and intr every cycle; directed
//               scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_timer_intc;

    localparam logic [31:0] RST_LOAD = 32'h0000_005A;
    localparam logic [7:0]  BASE_HI  = 8'hFF;
    localparam logic [11:0] A_CTRL   = 12'hFF0;
    localparam logic [11:0] A_LOAD   = 12'hFF4;
    localparam logic [11:0] A_COUNT  = 12'hFF8;
    localparam logic [11:0] A_STATUS = 12'hFFC;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0, int_ack = 1'b0;
    logic [31:0] Addr = '0, D_Out = '0;
    logic [31:0] dy1, dy3;
    logic        intr1, intr3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    io_timer_intc #(.BASE_ADDR(12'hFF0), .PRESCALE(1), .RESET_LOAD(RST_LOAD)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .Addr(Addr), .D_Out(D_Out), .int_ack(int_ack), .DY_io(dy1), .intr(intr1));

    io_timer_intc #(.BASE_ADDR(12'hFF0), .PRESCALE(3), .RESET_LOAD(RST_LOAD)) dut3 (
        .sys_clk(clk), .sys_rst(sys_rst), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .Addr(Addr), .D_Out(D_Out), .int_ack(int_ack), .DY_io(dy3), .intr(intr3));

    // ------------------------------------------------------------------
    // Behavioural model: architectural registers plus "request pending"
    // and "waiting for ack release" flags and a delayed TC event.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] load;
        logic [31:0] count;
        logic [1:0]  status;
        logic [31:0] phase;
        logic        pending;
        logic        hold;
        logic        tc_seen;
    } model_t;

    model_t m1, m3;

    function automatic model_t m_init();
        model_t n;
        n = '0;
        n.load = RST_LOAD;
        return n;
    endfunction

    function automatic model_t m_step(model_t m, int ps);
        model_t n = m;
        logic hit, wr_ok, tick, tc;
        logic [1:0] r;
        hit   = io_cs && (Addr[11:4] == BASE_HI);
        wr_ok = hit && io_wr && !io_rd;
        r     = Addr[3:2];
        tick  = 1'b0;
        tc    = 1'b0;
        if (m.ctrl[0]) begin
            tick    = (m.phase == 32'(ps - 1));
            n.phase = tick ? 32'd0 : m.phase + 32'd1;
        end else begin
            n.phase = 32'd0;
        end
        if (tick) begin
            if (m.count != 0) begin
                n.count = m.count - 1;
                tc = (m.count == 1);
            end else if (m.ctrl[1]) begin
                n.count = m.load;
            end
        end
        if (wr_ok && r == 2'd2) begin
            n.count = D_Out;
            tc = 1'b0;
        end
        if (tc && !m.ctrl[1]) n.ctrl[0] = 1'b0;
        if (wr_ok && r == 2'd0) n.ctrl = D_Out[2:0];
        if (wr_ok && r == 2'd1) n.load = D_Out;
        if (wr_ok && r == 2'd3) n.status = m.status & ~D_Out[1:0];
        if (m.tc_seen) begin
            n.status[0] = 1'b1;
            if (m.pending) n.status[1] = 1'b1;
        end
        if (m.pending) begin
            if (!m.ctrl[2]) n.pending = 1'b0;
            else if (int_ack) begin
                n.pending = 1'b0;
                n.hold    = 1'b1;
            end
        end else if (m.hold) begin
            if (!int_ack) n.hold = 1'b0;
        end else if (m.tc_seen && m.ctrl[2]) begin
            n.pending = 1'b1;
        end
        n.tc_seen = tc;
        return n;
    endfunction

    function automatic logic [31:0] m_read(model_t m);
        if (!(io_cs && io_rd && (Addr[11:4] == BASE_HI))) return 32'h0;
        case (Addr[3:2])
            2'd0:    return {29'd0, m.ctrl};
            2'd1:    return m.load;
            2'd2:    return m.count;
            default: return {30'd0, m.status};
        endcase
    endfunction

    always @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            m1 = m_init();
            m3 = m_init();
        end else begin
            m1 = m_step(m1, 1);
            m3 = m_step(m3, 3);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle model comparison, away from the rising edge.
    always @(negedge clk) begin
        check("model_dy_p1",   dy1,            m_read(m1));
        check("model_intr_p1", {31'd0, intr1}, {31'd0, m1.pending});
        check("model_dy_p3",   dy3,            m_read(m3));
        check("model_intr_p3", {31'd0, intr3}, {31'd0, m3.pending});
    end

    // ------------------------------------------------------------------
    // Bus helpers: each call occupies one clock window.
    // ------------------------------------------------------------------
    task automatic cyc(input logic cs, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        io_cs = cs; io_rd = rd; io_wr = wr; Addr = a; D_Out = d;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, 1'b1, {20'd0, a}, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [31:0] exp, input string nm);
        cyc(1'b1, 1'b1, 1'b0, {20'd0, a}, 32'd0);
        @(negedge clk);
        check(nm, dy1, exp);
    endtask

    task automatic intr_exp(input logic exp, input string nm);
        check(nm, {31'd0, intr1}, {31'd0, exp});
    endtask

    task automatic idle_intr(input logic exp, input string nm);
        idle();
        @(negedge clk);
        intr_exp(exp, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cnt_seq [5];
        logic        irq_seq [5];
        cnt_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        irq_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;

        // Reset values
        rd_exp(A_CTRL,   32'h0,    "rst_ctrl");
        rd_exp(A_LOAD,   RST_LOAD, "rst_load");
        rd_exp(A_COUNT,  32'h0,    "rst_count");
        rd_exp(A_STATUS, 32'h0,    "rst_status");
        intr_exp(1'b0, "rst_intr");

        // Auto-reload, period 4, interrupt one cycle after COUNT hits 0
        wr(A_LOAD, 32'd3);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 5; i++) begin
            rd_exp(A_COUNT, cnt_seq[i], "auto_count_seq");
            intr_exp(irq_seq[i], "auto_intr_seq");
        end

        // Ack held five cycles services exactly one request
        idle();
        int_ack = 1'b1;
        @(negedge clk);
        intr_exp(1'b1, "ack_before_sample");
        for (int i = 0; i < 4; i++) idle_intr(1'b0, "ack_held_low");
        idle();
        int_ack = 1'b0;
        @(negedge clk);
        intr_exp(1'b0, "ack_last_cycle");
        rd_exp(A_STATUS, 32'h1, "ack_status_no_ovr");
        intr_exp(1'b0, "ack_release_idle");
        rd_exp(A_STATUS, 32'h1, "rearm_status");
        intr_exp(1'b1, "rearm_new_request");

        // Unserviced request over further periods: overrun, then W1C
        repeat (4) idle();
        rd_exp(A_STATUS, 32'h3, "ovr_status");
        wr(A_CTRL, 32'h4);
        idle();
        wr(A_STATUS, 32'h2);
        rd_exp(A_STATUS, 32'h1, "w1c_ovr");
        intr_exp(1'b1, "w1c_intr_kept");
        rd_exp(A_COUNT, 32'h0, "frozen_count");
        rd_exp(A_CTRL, 32'h4, "frozen_ctrl");
        idle();
        int_ack = 1'b1;
        idle();
        int_ack = 1'b0;
        @(negedge clk);
        intr_exp(1'b0, "ack_pulse_drop");

        // One-shot: single TC clears EN, COUNT stays 0
        wr(A_STATUS, 32'h3);
        wr(A_LOAD, 32'd2);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h5);
        repeat (5) idle();
        rd_exp(A_CTRL, 32'h4, "oneshot_ctrl");
        rd_exp(A_COUNT, 32'h0, "oneshot_count");
        rd_exp(A_STATUS, 32'h1, "oneshot_status");
        intr_exp(1'b1, "oneshot_intr");
        idle();
        int_ack = 1'b1;
        idle();
        int_ack = 1'b0;
        idle_intr(1'b0, "oneshot_acked");

        // Clearing IE while pending withdraws the request
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h5);
        idle();
        idle();
        idle_intr(1'b1, "ie_pending");
        wr(A_CTRL, 32'h0);
        idle();
        idle_intr(1'b0, "ie_cleared_drop");

        // COUNT write on the 1->0 cycle wins and suppresses TC
        wr(A_STATUS, 32'h3);
        wr(A_LOAD, 32'd5);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h7);
        rd_exp(A_COUNT, 32'd2, "race_pre");
        wr(A_COUNT, 32'd10);
        rd_exp(A_COUNT, 32'd10, "race_write_wins");
        rd_exp(A_STATUS, 32'h0, "race_no_tc");
        intr_exp(1'b0, "race_no_intr");
        wr(A_CTRL, 32'h0);

        // Decode: outside BASE, read+write together, no chip select
        rd_exp(12'hFE8, 32'h0, "oob_read");
        wr(12'hFE4, 32'h55);
        rd_exp(A_LOAD, 32'd5, "oob_no_write");
        cyc(1'b1, 1'b1, 1'b1, {20'd0, A_LOAD}, 32'h77);
        @(negedge clk);
        check("rdwr_reads", dy1, 32'd5);
        rd_exp(A_LOAD, 32'd5, "rdwr_no_write");
        cyc(1'b0, 1'b1, 1'b0, {20'd0, A_LOAD}, 32'h0);
        @(negedge clk);
        check("no_cs_read", dy1, 32'h0);

        // Asynchronous reset while a request is pending
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h5);
        repeat (3) idle();
        @(negedge clk);
        intr_exp(1'b1, "pre_reset_intr");
        @(posedge clk);
        #2 sys_rst = 1'b0;
        #1 intr_exp(1'b0, "reset_async_intr");
        rd_exp(A_COUNT,  32'h0,    "inrst_count");
        rd_exp(A_CTRL,   32'h0,    "inrst_ctrl");
        rd_exp(A_STATUS, 32'h0,    "inrst_status");
        rd_exp(A_LOAD,   RST_LOAD, "inrst_load");
        @(posedge clk);
        #1 sys_rst = 1'b1;
        repeat (3) idle();
        rd_exp(A_COUNT, 32'h0, "post_reset_count");
        intr_exp(1'b0, "post_reset_intr");

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_io_timer_intc
`default_nettype wire
